// File: rtl/param_mux_sequencer_if.sv
// Handshake bundle between the neuron output bank, the word sequencer and its serial consumer.
interface param_mux_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_IN   = 32,
    parameter int unsigned SEL_W  = 5
) ();
    logic [N_IN*DATA_W-1:0] d_in;
    logic [SEL_W-1:0]       sel;
    logic                   sel_valid;
    logic                   sel_ready;
    logic                   scan_start;
    logic [SEL_W-1:0]       scan_first;
    logic [SEL_W-1:0]       scan_last;
    logic [DATA_W-1:0]      d_out;
    logic [SEL_W-1:0]       out_idx;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   busy;
    logic                   scan_done;
    logic                   sel_err;

    modport master (
        output d_in, sel, sel_valid, scan_start, scan_first, scan_last, out_ready,
        input  sel_ready, d_out, out_idx, out_valid, out_last, busy, scan_done, sel_err
    );

    modport slave (
        input  d_in, sel, sel_valid, scan_start, scan_first, scan_last, out_ready,
        output sel_ready, d_out, out_idx, out_valid, out_last, busy, scan_done, sel_err
    );
endinterface

// File: rtl/param_mux_sequencer.sv
// Registered N:1 word selector: direct indexed reads or autonomous first..last scans,
// with valid/ready flow control on both request and output sides.
module param_mux_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_IN   = 32,
    parameter int unsigned SEL_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    param_mux_sequencer_if.slave bus
);
    localparam int unsigned N_SLOT = 1 << SEL_W;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [DATA_W-1:0]   d_out_q, d_out_d;
    logic [SEL_W-1:0]    out_idx_q, out_idx_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                scan_done_q, scan_done_d;
    logic                sel_err_q, sel_err_d;
    logic                ready_en_q;

    logic                load_en_c;
    logic                sel_ready_c;
    logic                sel_oob_c;
    logic                scan_bad_c;
    logic [SEL_W-1:0]    rd_idx_c;
    logic [DATA_W-1:0]   rd_word_c;
    logic [DATA_W-1:0]   words [N_SLOT];

    // Pad the word table to the full index range so out-of-range selects read zero.
    for (genvar k = 0; k < N_SLOT; k++) begin : g_word
        if (k < N_IN) begin : g_live
            assign words[k] = bus.d_in[k*DATA_W +: DATA_W];
        end else begin : g_pad
            assign words[k] = '0;
        end
    end

    assign load_en_c  = ~out_valid_q | bus.out_ready;
    assign sel_oob_c  = 32'(bus.sel) >= N_IN;
    assign scan_bad_c = (bus.scan_first > bus.scan_last) || (32'(bus.scan_last) >= N_IN);
    assign rd_idx_c   = (state_q == SCAN) ? idx_q : bus.sel;
    assign rd_word_c  = words[rd_idx_c];

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        d_out_d     = d_out_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        busy_d      = busy_q;
        scan_done_d = 1'b0;
        sel_err_d   = 1'b0;
        sel_ready_c = 1'b0;

        case (state_q)
            IDLE: begin
                // A scan request wins over a simultaneous direct request.
                if (bus.scan_start) begin
                    if (scan_bad_c) begin
                        sel_err_d = 1'b1;
                    end else begin
                        idx_d   = bus.scan_first;
                        last_d  = bus.scan_last;
                        busy_d  = 1'b1;
                        state_d = SCAN;
                    end
                end else begin
                    sel_ready_c = ready_en_q & load_en_c;
                    if (bus.sel_valid & sel_ready_c) begin
                        d_out_d     = rd_word_c;
                        out_idx_d   = bus.sel;
                        out_last_d  = 1'b0;
                        out_valid_d = 1'b1;
                        sel_err_d   = sel_oob_c;
                    end
                end
            end
            SCAN: begin
                if (load_en_c) begin
                    d_out_d     = rd_word_c;
                    out_idx_d   = idx_q;
                    out_last_d  = (idx_q == last_q);
                    out_valid_d = 1'b1;
                    if (idx_q == last_q) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q & bus.out_ready) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    scan_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; ready_en holds off requests until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            last_q      <= '0;
            d_out_q     <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
            sel_err_q   <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            d_out_q     <= d_out_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            scan_done_q <= scan_done_d;
            sel_err_q   <= sel_err_d;
            ready_en_q  <= 1'b1;
        end
    end

    assign bus.sel_ready = sel_ready_c;
    assign bus.d_out     = d_out_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.scan_done = scan_done_q;
    assign bus.sel_err   = sel_err_q;
endmodule
